// File: rtl/mul8u_arb2_if.sv
// Request/response bundle between two multiply clients and mul8u_arb2.
// master: client side (valid/operands/rsp_ready), slave: the arbiter.
interface mul8u_arb2_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_y;
    logic        busy;
    logic [15:0] ops_done;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_y,
        input  busy, ops_done
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_y,
        output busy, ops_done
    );
endinterface

// File: rtl/mul8u_arb2.sv
// Two-channel round-robin front end for one shared 8x8 unsigned multiplier.
// Ports: clk, rst (sync, active-high), bus (mul8u_arb2_if.slave).
module mul8u_behav (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] y
);
    assign y = {8'd0, a} * {8'd0, b};
endmodule

module mul8u_arb2 #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mul8u_arb2_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        prio;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic        id_r;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_y;
    logic [15:0] ops_cnt;
    logic [15:0] prod;
    logic        g0;
    logic        g1;

    // Grant choice: a lone requester wins, a tie goes to prio.
    assign g0 = bus.req0_valid && (!bus.req1_valid || !prio);
    assign g1 = bus.req1_valid && (!bus.req0_valid || prio);

    assign bus.req0_ready = !rst && (state == IDLE) && g0;
    assign bus.req1_ready = !rst && (state == IDLE) && g1;

    mul8u_behav u_mul (
        .a (a_r),
        .b (b_r),
        .y (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= PRIO_INIT;
            a_r       <= 8'd0;
            b_r       <= 8'd0;
            id_r      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= 16'd0;
            ops_cnt   <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (g0) begin
                        a_r   <= bus.req0_a;
                        b_r   <= bus.req0_b;
                        id_r  <= 1'b0;
                        prio  <= 1'b1;
                        state <= CALC;
                    end else if (g1) begin
                        a_r   <= bus.req1_a;
                        b_r   <= bus.req1_b;
                        id_r  <= 1'b1;
                        prio  <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_y     <= prod;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_cnt   <= ops_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_y     = rsp_y;
    assign bus.busy      = (state != IDLE);
    assign bus.ops_done  = ops_cnt;
endmodule

// File: tb/tb_mul8u_arb2.sv
// Directed plus random checks of mul8u_arb2 against a transaction model.
// Model tracks round-robin priority, products and completion count.
module tb_mul8u_arb2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   prio = 1'b0;
    logic [15:0] exp_ops = 16'd0;

    mul8u_arb2_if bus ();

    mul8u_arb2 #(.PRIO_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit v0, input bit v1,
                           input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_a = a0;
        bus.req0_b = b0;
        bus.req1_a = a1;
        bus.req1_b = b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(1, 1, 8'd3, 8'd4, 8'd5, 8'd6);
        #1;
        chk("rst_rdy0", 32'(bus.req0_ready), 0);
        chk("rst_rdy1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        chk("rst_vld", 32'(bus.rsp_valid), 0);
        chk("rst_y", 32'(bus.rsp_y), 0);
        chk("rst_id", 32'(bus.rsp_id), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ops", 32'(bus.ops_done), 0);
        rst = 1'b0;
        set_req(0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
        prio = 1'b0;
        exp_ops = 16'd0;
    endtask

    // One full transaction; loser of a tie drops valid after the grant.
    task automatic op(input bit v0, input bit v1,
                      input logic [7:0] a0, input logic [7:0] b0,
                      input logic [7:0] a1, input logic [7:0] b1,
                      input int stall);
        int g;
        int n;
        logic [15:0] ey;
        g  = (v0 && v1) ? int'(prio) : (v0 ? 0 : 1);
        ey = (g == 1) ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
        @(negedge clk);
        bus.rsp_ready = (stall == 0);
        set_req(v0, v1, a0, b0, a1, b1);
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rdy0", 32'(bus.req0_ready), 32'(g == 0));
        chk("rdy1", 32'(bus.req1_ready), 32'(g == 1));
        prio = (g == 0);
        @(negedge clk);
        set_req(0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("calc_busy", 32'(bus.busy), 1);
        chk("calc_vld", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("rsp_vld", 32'(bus.rsp_valid), 1);
        chk("rsp_y", 32'(bus.rsp_y), 32'(ey));
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        for (int i = 0; i < stall; i++) begin
            set_req(1, 1, 8'd9, 8'd9, 8'd9, 8'd9);
            #1;
            chk("bp_rdy0", 32'(bus.req0_ready), 0);
            chk("bp_rdy1", 32'(bus.req1_ready), 0);
            chk("bp_vld", 32'(bus.rsp_valid), 1);
            chk("bp_y", 32'(bus.rsp_y), 32'(ey));
            chk("bp_id", 32'(bus.rsp_id), 32'(g));
            chk("bp_ops", 32'(bus.ops_done), 32'(exp_ops));
            @(negedge clk);
        end
        set_req(0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
        bus.rsp_ready = 1'b1;
        exp_ops = exp_ops + 16'd1;
        @(negedge clk);
        chk("done_vld", 32'(bus.rsp_valid), 0);
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_ops", 32'(bus.ops_done), 32'(exp_ops));
    endtask

    initial begin
        int got;
        int cyc;
        int last;
        logic [15:0] ey;
        bit v0;
        bit v1;
        set_req(0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
        bus.rsp_ready = 1'b1;
        do_reset();

        op(1, 0, 8'd13, 8'd7, 8'd0, 8'd0, 0);
        op(0, 1, 8'd0, 8'd0, 8'd0, 8'd255, 0);
        op(0, 1, 8'd0, 8'd0, 8'd255, 8'd0, 0);
        op(0, 1, 8'd0, 8'd0, 8'd255, 8'd255, 0);
        op(0, 1, 8'd0, 8'd0, 8'd128, 8'd2, 0);

        // Contention with valids held: alternating ids, 3 cycles apart.
        do_reset();
        @(negedge clk);
        set_req(1, 1, 8'd200, 8'd100, 8'd13, 8'd7);
        got = 0;
        cyc = 0;
        last = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid) begin
                ey = prio ? 16'd91 : 16'd20000;
                chk("cont_id", 32'(bus.rsp_id), 32'(prio));
                chk("cont_y", 32'(bus.rsp_y), 32'(ey));
                chk("cont_ops", 32'(bus.ops_done), 32'(exp_ops));
                if (got > 0) chk("cont_gap", 32'(cyc - last), 3);
                last = cyc;
                prio = ~prio;
                exp_ops = exp_ops + 16'd1;
                got++;
                if (got == 4) set_req(0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
            end
        end
        chk("cont_cnt", 32'(got), 4);
        @(negedge clk);
        chk("cont_ops_end", 32'(bus.ops_done), 32'(exp_ops));
        chk("cont_idle", 32'(bus.busy), 0);

        op(1, 1, 8'd17, 8'd19, 8'd23, 8'd29, 5);

        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            op(v0, v1, 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset while an operation is in CALC.
        @(negedge clk);
        set_req(1, 0, 8'd255, 8'd255, 8'd0, 8'd0);
        #1;
        chk("mid_rdy0", 32'(bus.req0_ready), 1);
        @(negedge clk);
        set_req(0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("mid_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prio = 1'b0;
        exp_ops = 16'd0;
        chk("mid_vld", 32'(bus.rsp_valid), 0);
        chk("mid_y", 32'(bus.rsp_y), 0);
        chk("mid_id", 32'(bus.rsp_id), 0);
        chk("mid_busy0", 32'(bus.busy), 0);
        chk("mid_ops", 32'(bus.ops_done), 0);
        @(negedge clk);
        chk("mid_novld", 32'(bus.rsp_valid), 0);
        op(1, 1, 8'd2, 8'd3, 8'd4, 8'd5, 0);

        // Preload the completion counter near its top and wrap it.
        @(negedge clk);
        force dut.ops_cnt = 16'hFFFE;
        #1;
        release dut.ops_cnt;
        exp_ops = 16'hFFFE;
        op(0, 1, 8'd0, 8'd0, 8'd1, 8'd1, 0);
        op(1, 0, 8'd255, 8'd1, 8'd0, 8'd0, 0);
        chk("wrap", 32'(bus.ops_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
